// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB-Lite slave in front of a word-wide internal array with WAIT_STATES wait cycles per transfer.
// Define AHB_RESP_ERR_EN to add ERROR responses for out-of-range or misaligned transfers.
module ahb_sram_responder #(
    parameter int WAIT_STATES = 1,
    parameter int MEM_DEPTH   = 256
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef AHB_RESP_ERR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        dphase_q, dphase_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;

    logic [31:0] mem [MEM_DEPTH];

    logic        accept;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [3:0]  lane_en;
    logic        mem_we;
    logic        unused_sig;

    // Only a genuine NONSEQ/SEQ phase while idle starts a transfer; ST_ERR2 therefore drops one.
    assign accept = hsel && hready && htrans[1] && (state_q == ST_IDLE);

`ifdef AHB_RESP_ERR_EN
    logic illegal;
    assign illegal = ({2'b00, haddr[31:2]} >= 32'(MEM_DEPTH)) ||
                     (hsize > 3'd2) ||
                     ((hsize == 3'd1) && haddr[0]) ||
                     ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
`endif

    // Oversized transfers collapse to a word and low address bits are aligned to the size.
    always_comb begin
        acc_size = (hsize > 3'd2) ? 2'd2 : hsize[1:0];
        acc_addr = haddr;
        if (acc_size == 2'd1) begin
            acc_addr[0] = 1'b0;
        end
        if (acc_size == 2'd2) begin
            acc_addr[1:0] = 2'b00;
        end
    end

    assign word_idx = addr_q[AW+1:2];
    assign rd_word  = mem[word_idx];

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_en[gi] = (size_q == 2'd2) ||
                             ((size_q == 2'd1) && (addr_q[1] == 1'(gi / 2))) ||
                             ((size_q == 2'd0) && (addr_q[1:0] == 2'(gi)));
        assign wr_word[gi*8 +: 8] = lane_en[gi] ? hwdata[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end

    // The last data-phase cycle is the one spent back in ST_IDLE with a transfer still open.
    assign mem_we = dphase_q && write_q && (state_q == ST_IDLE) && !hreset;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        dphase_d    = dphase_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        case (state_q)
            ST_IDLE: begin
                dphase_d    = 1'b0;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                if (accept) begin
`ifdef AHB_RESP_ERR_EN
                    if (illegal) begin
                        state_d     = ST_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = 1'b1;
                    end else
`endif
                    begin
                        addr_d   = acc_addr;
                        write_d  = hwrite;
                        size_d   = acc_size;
                        dphase_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d     = ST_WAIT;
                            cnt_d       = 3'(WAIT_STATES);
                            hreadyout_d = 1'b0;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d     = ST_IDLE;
                    cnt_d       = 3'd0;
                    hreadyout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef AHB_RESP_ERR_EN
            ST_ERR1: begin
                state_d     = ST_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b1;
            end
            ST_ERR2: begin
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                dphase_d    = 1'b0;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 32'h0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            dphase_q    <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            dphase_q    <= dphase_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Array contents survive reset, so the write port carries no reset.
    always_ff @(posedge hclk) begin
        if (mem_we) begin
            mem[word_idx] <= wr_word;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = (dphase_q && !write_q) ? rd_word : 32'h0;

    assign unused_sig = ^{hburst, hprot, hmastlock, htrans[0], addr_q};
endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb_ahb_sram_responder: drives two responders (one wait state, zero wait states) with random AHB traffic;
// a monitor checks every data phase against expectations queued from a byte-level memory model.
module tb_ahb_sram_responder;
    localparam int DEPTH = 256;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        bit          resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [1:0]        hreadyout_v;
    logic [1:0]        hresp_v;
    logic [1:0][31:0]  hrdata_v;

    int   active;
    exp_t exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int   n_cmp;
    int   n_bad;
    bit   mon_en;
    bit   prev_err;
    bit   pend;
    int   waits;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ahb_sram_responder #(
            .WAIT_STATES(gi == 0 ? 1 : 0),
            .MEM_DEPTH  (DEPTH)
        ) u_dut (
            .hclk     (clk),
            .hreset   (hreset),
            .hsel     (hsel && (active == gi)),
            .haddr    (haddr),
            .hwrite   (hwrite),
            .hsize    (hsize),
            .hburst   (hburst),
            .hprot    (hprot),
            .hmastlock(hmastlock),
            .htrans   (htrans),
            .hready   (hreadyout_v[gi]),
            .hwdata   (hwdata),
            .hreadyout(hreadyout_v[gi]),
            .hresp    (hresp_v[gi]),
            .hrdata   (hrdata_v[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, active, act, want);
        end
    endtask

    task automatic fail_note(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s dut%0d: wait bound expired", name, active);
    endtask

    // Reference model: byte-addressed view of the array, applied in program order.
    function automatic exp_t model(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                   input logic [31:0] wd);
        exp_t e;
        int idx;
        int nbytes;
        int lo;
        e.wr    = wr;
        e.addr  = a;
        e.size  = sz;
        e.resp  = 1'b0;
        e.rdata = 32'h0;
        e.waits = (active == 0) ? 1 : 0;
`ifdef AHB_RESP_ERR_EN
        if ((a >> 2) >= DEPTH || sz > 3'd2 || (sz == 3'd1 && a % 2 != 0) ||
            (sz == 3'd2 && a % 4 != 0)) begin
            e.resp  = 1'b1;
            e.waits = 1;
            return e;
        end
`endif
        idx    = int'((a >> 2) % DEPTH);
        nbytes = (sz >= 3'd2) ? 4 : (1 << sz);
        lo     = int'(a % 4) / nbytes * nbytes;
        if (wr) begin
            for (int l = lo; l < lo + nbytes; l++) begin
                model_mem[idx][8*l +: 8] = wd[8*l +: 8];
            end
        end else begin
            e.rdata = model_mem[idx];
        end
        return e;
    endfunction

    // Present one address phase, hold it until accepted, then drive its write data.
    task automatic present(input bit track, input logic s, input logic [1:0] t, input bit wr,
                           input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        bit acc;
        bit err_now;
        int guard;
        hsel      = s;
        htrans    = t;
        hwrite    = wr;
        haddr     = a;
        hsize     = sz;
        hburst    = 3'($urandom);
        hprot     = 4'($urandom);
        hmastlock = 1'($urandom);
        err_now   = 1'b0;
        if (s && t[1] && track && !prev_err) begin
            e = model(wr, a, sz, wd);
            exp_q.push_back(e);
            err_now = e.resp;
        end
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 40) begin
            @(negedge clk);
            acc = hreadyout_v[active];
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) fail_note("addr_accept_timeout");
        prev_err = err_now;
        hwdata   = wd;
    endtask

    task automatic idle_cycle();
        present(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            idle_cycle();
            guard++;
        end
        if (exp_q.size() != 0) begin
            fail_note("drain_timeout");
            exp_q.delete();
        end
        idle_cycle();
    endtask

    // Monitor: every data-phase cycle is compared with the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        bit ro;
        bit done_err;
        bit nxt;
        if (!mon_en) begin
            pend  = 1'b0;
            waits = 0;
        end else begin
            ro       = hreadyout_v[active];
            done_err = 1'b0;
            nxt      = pend;
            if (pend) begin
                if (exp_q.size() == 0) begin
                    fail_note("unexpected_transfer");
                    nxt = 1'b0;
                end else if (!ro) begin
                    waits++;
                    check("hresp_wait", 32'(hresp_v[active]), 32'(exp_q[0].resp));
                    if (waits > 20) begin
                        fail_note("data_phase_timeout");
                        void'(exp_q.pop_front());
                        nxt   = 1'b0;
                        waits = 0;
                    end
                end else begin
                    e = exp_q.pop_front();
                    check("wait_cycles", 32'(waits), 32'(e.waits));
                    check("hresp", 32'(hresp_v[active]), 32'(e.resp));
                    check("hrdata", hrdata_v[active], e.rdata);
                    $display("dut%0d %s addr=%h size=%0d resp=%0d hrdata=%h waits=%0d",
                             active, e.wr ? "WR" : "RD", e.addr, e.size, hresp_v[active],
                             hrdata_v[active], waits);
                    done_err = e.resp;
                    nxt      = 1'b0;
                    waits    = 0;
                end
            end else begin
                check("idle_hreadyout", 32'(ro), 32'd1);
                check("idle_hresp", 32'(hresp_v[active]), 32'd0);
                check("idle_hrdata", hrdata_v[active], 32'h0);
            end
            // A phase offered in the final ERROR cycle is cancelled, never started.
            if (ro && hsel && htrans[1] && !done_err) nxt = 1'b1;
            pend = nxt;
        end
    end

    task automatic reset_test();
        drain();
        mon_en = 1'b0;
        present(1'b0, 1'b1, 2'd2, 1'b1, 32'h8, 3'd2, 32'h77);
        hsel   = 1'b0;
        htrans = 2'd0;
        #2 hreset = 1'b1;
        #1;
        check("rst_hreadyout", 32'(hreadyout_v[active]), 32'd1);
        check("rst_hresp", 32'(hresp_v[active]), 32'd0);
        check("rst_hrdata", hrdata_v[active], 32'h0);
        @(posedge clk);
        #1 hreset = 1'b0;
        prev_err = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        present(1'b1, 1'b1, 2'd2, 1'b0, 32'h8, 3'd2, 32'h0);
    endtask

    task automatic run_dut(input int d);
        logic [31:0] a;
        logic [2:0]  sz;
        int r;
        drain();
        mon_en   = 1'b0;
        active   = d;
        prev_err = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 mon_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            present(1'b1, 1'b1, 2'd2, 1'b1, 32'(i * 4), 3'd2, $urandom);
        end
        present(1'b1, 1'b1, 2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        present(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
        present(1'b1, 1'b1, 2'd2, 1'b1, 32'h10, 3'd2, 32'h11223344);
        present(1'b1, 1'b1, 2'd2, 1'b1, 32'h13, 3'd0, 32'hAAAAAAAA);
        present(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
        present(1'b1, 1'b1, 2'd2, 1'b1, 32'h20, 3'd2, 32'h5);
        present(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
        present(1'b1, 1'b1, 2'd1, 1'b1, 32'h20, 3'd2, 32'hFFFFFFFF);
        present(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
        present(1'b1, 1'b1, 2'd2, 1'b0, 32'h402, 3'd2, 32'h0);
        present(1'b1, 1'b1, 2'd2, 1'b1, 32'h10, 3'd2, 32'h99999999);
        present(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
        present(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                present(1'b1, 1'($urandom), 2'($urandom_range(0, 1)), 1'($urandom), $urandom,
                        3'($urandom), $urandom);
            end else if (r == 1) begin
                present(1'b1, 1'b0, 2'd2, 1'($urandom), $urandom, 3'd2, $urandom);
            end else begin
                sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                a  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63));
                present(1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd3, 1'($urandom), a, sz,
                        $urandom);
            end
        end
        reset_test();
        drain();
    endtask

    initial begin
        hreset    = 1'b1;
        hsel      = 1'b0;
        haddr     = 32'h0;
        hwrite    = 1'b0;
        hsize     = 3'd0;
        hburst    = 3'd0;
        hprot     = 4'd0;
        hmastlock = 1'b0;
        htrans    = 2'd0;
        hwdata    = 32'h0;
        active    = 0;
        mon_en    = 1'b0;
        prev_err  = 1'b0;
        pend      = 1'b0;
        waits     = 0;
        n_cmp     = 0;
        n_bad     = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_hreadyout", 32'(hreadyout_v[d]), 32'd1);
            check("reset_hresp", 32'(hresp_v[d]), 32'd0);
            check("reset_hrdata", hrdata_v[d], 32'h0);
        end
        hreset = 1'b0;
        @(posedge clk);
        #1;
        run_dut(0);
        run_dut(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
